sd_cmd_responder: RTL

// Card-side end of the SD CMD line: deserialises 48-bit host command frames, checks framing and CRC7,

---
 rtl/sd_cmd_pkg.sv | 26 ++
 rtl/sd_cmd_responder_if.sv | 22 ++
 rtl/sd_crc7.sv | 24 ++
 rtl/sd_cmd_responder.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/sd_cmd_pkg.sv
// Shared definitions for the SD CMD line: FSM states, frame lengths, CRC7 step.
package sd_cmd_pkg;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_SHIFT  = 3'd1,
    CHECK     = 3'd2,
    WAIT_RESP = 3'd3,
    NCR_WAIT  = 3'd4,
    TX        = 3'd5
  } cmd_state_t;

  localparam logic [6:0] CRC7_POLY = 7'h09;
  localparam int         CMD_LEN   = 48;
  localparam int         R1_LEN    = 48;
  localparam int         R2_LEN    = 136;
  localparam logic [5:0] R2_RSVD   = 6'b111111;

  // One serial CRC7 step, g(x) = x^7 + x^3 + 1.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
    logic fb;
    fb = bit_in ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_cmd_responder_if.sv
// Handshake between the CMD responder and the card logic behind it.
interface sd_cmd_responder_if;
  logic         cmd_strobe;
  logic [5:0]   cmd_index;
  logic [31:0]  cmd_argument;
  logic         resp_strobe;
  logic         resp_none;
  logic         resp_long;
  logic [127:0] resp_payload;

  // Card logic: consumes commands, supplies responses.
  modport master (
    input  cmd_strobe, cmd_index, cmd_argument,
    output resp_strobe, resp_none, resp_long, resp_payload
  );

  // Responder: produces commands, consumes responses.
  modport slave (
    output cmd_strobe, cmd_index, cmd_argument,
    input  resp_strobe, resp_none, resp_long, resp_payload
  );
endinterface

// File: rtl/sd_crc7.sv
// Serial CRC7 accumulator; clear together with enable restarts from the given bit.
module sd_crc7
  import sd_cmd_pkg::*;
(
  input  logic       clk_SD,
  input  logic       reset_host,
  input  logic       clear,
  input  logic       enable,
  input  logic       bit_in,
  output logic [6:0] crc
);

  // Accumulate one bit per enabled cycle.
  always_ff @(posedge clk_SD) begin
    if (reset_host) begin
      crc <= 7'h00;
    end else if (clear) begin
      crc <= enable ? crc7_step(7'h00, bit_in) : 7'h00;
    end else if (enable) begin
      crc <= crc7_step(crc, bit_in);
    end
  end

endmodule

// File: rtl/sd_cmd_responder.sv
// Card-side SD CMD line: receives 48-bit commands, hands them to card logic,
// and serialises the R1-type or R2 response.
module sd_cmd_responder
  import sd_cmd_pkg::*;
#(
  parameter int NCR          = 2,
  parameter int RESP_TIMEOUT = 64
) (
  input  logic                clk_SD,
  input  logic                reset_host,
  input  logic                cmd_pin_in,
  output logic                cmd_pin_out,
  output logic                cmd_pin_oe,
  sd_cmd_responder_if.slave   card,
  output logic                busy,
  output logic                crc_error,
  output logic                frame_error,
  output logic                resp_done,
  output logic                resp_timeout
);

  localparam int WAIT_MAX = (RESP_TIMEOUT > NCR) ? RESP_TIMEOUT : NCR;
  localparam int WW       = $clog2(WAIT_MAX + 1);

  cmd_state_t    state;
  logic [7:0]    bit_cnt;
  logic [WW-1:0] wait_cnt;
  logic [47:0]   rx_shift;
  logic [135:0]  tx_shift;
  logic          resp_long_reg;
  logic [6:0]    rx_crc;
  logic [6:0]    tx_crc;
  logic          rx_crc_en;
  logic          tx_crc_en;
  logic          tx_bit;
  logic [7:0]    tx_len;

  // RX CRC covers start bit through argument; restarted on every start bit.
  assign rx_crc_en = ((state == RX_IDLE) && !cmd_pin_in) ||
                     ((state == RX_SHIFT) && (bit_cnt <= 8'(CMD_LEN - 9)));

  sd_crc7 u_rx_crc (
    .clk_SD     (clk_SD),
    .reset_host (reset_host),
    .clear      (state == RX_IDLE),
    .enable     (rx_crc_en),
    .bit_in     (cmd_pin_in),
    .crc        (rx_crc)
  );

  // TX CRC covers the first 40 bits of a short response as they go out.
  assign tx_crc_en = (state == TX) && !resp_long_reg && (bit_cnt < 8'(R1_LEN - 8));

  sd_crc7 u_tx_crc (
    .clk_SD     (clk_SD),
    .reset_host (reset_host),
    .clear      (state != TX),
    .enable     (tx_crc_en),
    .bit_in     (tx_shift[135]),
    .crc        (tx_crc)
  );

  assign tx_len = resp_long_reg ? 8'(R2_LEN) : 8'(R1_LEN);
  assign busy   = (state != RX_IDLE);

  // Next line bit: the CRC field of a short response is taken from the TX CRC generator.
  always_comb begin
    tx_bit = tx_shift[135];
    if (!resp_long_reg) begin
      for (int i = 0; i < 7; i++) begin
        if (bit_cnt == 8'(R1_LEN - 2 - i)) tx_bit = tx_crc[i];
      end
    end
  end

  // Main FSM with registered line drive, handshake and status pulses.
  always_ff @(posedge clk_SD) begin
    if (reset_host) begin
      state             <= RX_IDLE;
      bit_cnt           <= 8'd0;
      wait_cnt          <= '0;
      rx_shift          <= '0;
      tx_shift          <= '0;
      resp_long_reg     <= 1'b0;
      cmd_pin_out       <= 1'b1;
      cmd_pin_oe        <= 1'b0;
      card.cmd_strobe   <= 1'b0;
      card.cmd_index    <= 6'd0;
      card.cmd_argument <= 32'd0;
      crc_error         <= 1'b0;
      frame_error       <= 1'b0;
      resp_done         <= 1'b0;
      resp_timeout      <= 1'b0;
    end else begin
      card.cmd_strobe <= 1'b0;
      crc_error       <= 1'b0;
      frame_error     <= 1'b0;
      resp_done       <= 1'b0;
      resp_timeout    <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (!cmd_pin_in) begin
            rx_shift <= '0;
            bit_cnt  <= 8'd1;
            state    <= RX_SHIFT;
          end
        end
        RX_SHIFT: begin
          rx_shift <= {rx_shift[46:0], cmd_pin_in};
          bit_cnt  <= bit_cnt + 8'd1;
          if (bit_cnt == 8'(CMD_LEN - 1)) state <= CHECK;
        end
        CHECK: begin
          if (rx_shift[47] || !rx_shift[46] || !rx_shift[0]) begin
            frame_error <= 1'b1;
            state       <= RX_IDLE;
          end else if (rx_crc != rx_shift[7:1]) begin
            crc_error <= 1'b1;
            state     <= RX_IDLE;
          end else begin
            card.cmd_index    <= rx_shift[45:40];
            card.cmd_argument <= rx_shift[39:8];
            card.cmd_strobe   <= 1'b1;
            wait_cnt          <= '0;
            state             <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          if (card.resp_none) begin
            state <= RX_IDLE;
          end else if (card.resp_strobe) begin
            resp_long_reg <= card.resp_long;
            // Long: payload bit 0 is overwritten by the forced end bit.
            tx_shift <= card.resp_long ?
                        ({2'b00, R2_RSVD, card.resp_payload} | 136'h1) :
                        {2'b00, card.cmd_index, card.resp_payload[31:0], 7'h00, 1'b1, 88'h0};
            wait_cnt <= '0;
            state    <= NCR_WAIT;
          end else if (wait_cnt == WW'(RESP_TIMEOUT - 1)) begin
            resp_timeout <= 1'b1;
            state        <= RX_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        NCR_WAIT: begin
          if (wait_cnt == WW'(NCR - 1)) begin
            bit_cnt <= 8'd0;
            state   <= TX;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        TX: begin
          if (bit_cnt == tx_len) begin
            cmd_pin_oe  <= 1'b0;
            cmd_pin_out <= 1'b1;
            resp_done   <= 1'b1;
            state       <= RX_IDLE;
          end else begin
            cmd_pin_oe  <= 1'b1;
            cmd_pin_out <= tx_bit;
            tx_shift    <= {tx_shift[134:0], 1'b0};
            bit_cnt     <= bit_cnt + 8'd1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule
